// File: rtl/fft_sdf_ctrl.sv
// Control sequencer for a radix-2 SDF FFT: stage strobes/ctrl, zero-flush and output framing.
// Optional completed-frame counter enabled by defining FFT_SDF_CTRL_FRAME_CNT_EN.
module fft_sdf_ctrl #(
  parameter int LOG2N            = 4,
  parameter bit FLUSH_EN_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sop,
  output logic             in_ready,
  input  logic             flush_en,
  output logic [LOG2N-1:0] bf_valid,
  output logic [LOG2N-1:0] bf_ctrl,
  output logic             zero_inj,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [LOG2N-1:0] out_idx,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] FL_LAST = LOG2N'(N - 2);
  localparam logic [LOG2N-1:0] ONE     = LOG2N'(1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state_q;
  logic             flush_en_q;
  logic [LOG2N-1:0] flush_cnt_q;
  logic [LOG2N-1:0] fill_q;
  logic [LOG2N-1:0] out_idx_q;
  logic [LOG2N-1:0] ctrl_q;
  logic [LOG2N-1:0] qpipe_q;
  logic [LOG2N-2:0] vpipe_q;
  logic [LOG2N-2:0] spipe_q;
  logic [LOG2N-1:0] cnt_q   [LOG2N];
  logic [LOG2N-1:0] cnt_eff [LOG2N];

  logic             sop_acc, data_acc, boundary, flushing, adv;
  logic             restart, flush_done, qual;
  logic [LOG2N-1:0] ssop;

  // Frame boundary in RUN: the previous frame has just completed (cnt_0 wrapped).
  assign boundary   = (state_q == RUN) && (cnt_q[0] == '0);
  assign flushing   = (state_q == FLUSH) || (boundary && flush_en_q);
  assign sop_acc    = in_valid && in_sop;
  assign in_ready   = !flushing || sop_acc;
  assign data_acc   = in_valid && !in_sop && (state_q == RUN) && !boundary;
  assign zero_inj   = flushing && !sop_acc;
  assign adv        = sop_acc || data_acc || zero_inj;
  assign restart    = sop_acc && ((state_q == IDLE) || ((state_q == RUN) && !boundary));
  assign flush_done = zero_inj && (flush_cnt_q == FL_LAST);
  assign qual       = (fill_q == CNT_MAX) && !restart;

  assign bf_valid = {vpipe_q, adv};
  assign ssop     = {spipe_q, sop_acc};

  always_comb begin
    for (int s = 0; s < LOG2N; s++) begin
      cnt_eff[s] = ssop[s] ? '0 : cnt_q[s];
      bf_ctrl[s] = bf_valid[s] ? cnt_eff[s][LOG2N-1-s] : ctrl_q[s];
    end
  end

  assign out_valid = qpipe_q[LOG2N-1];
  assign out_idx   = out_idx_q;
  assign out_sop   = out_valid && (out_idx_q == '0);
  assign out_eop   = out_valid && (out_idx_q == CNT_MAX);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE:    if (sop_acc) state_q <= RUN;
        RUN:     if (flush_done) state_q <= IDLE;
                 else if (zero_inj) state_q <= FLUSH;
        FLUSH:   if (sop_acc) state_q <= RUN;
                 else if (flush_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (sop_acc || flush_done) flush_cnt_q <= '0;
      else if (zero_inj)         flush_cnt_q <= flush_cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_en_q <= FLUSH_EN_DEFAULT;
      vpipe_q    <= '0;
      spipe_q    <= '0;
      qpipe_q    <= '0;
      ctrl_q     <= '0;
      fill_q     <= '0;
      out_idx_q  <= '0;
      for (int s = 0; s < LOG2N; s++) cnt_q[s] <= '0;
    end else begin
      flush_en_q <= flush_en;
      vpipe_q    <= bf_valid[LOG2N-2:0];
      spipe_q    <= ssop[LOG2N-2:0];
      // Output qualification rides alongside the stage valids to the last stage.
      qpipe_q    <= {qpipe_q[LOG2N-2:0], adv && qual};
      ctrl_q     <= bf_ctrl;
      for (int s = 0; s < LOG2N; s++)
        if (bf_valid[s]) cnt_q[s] <= cnt_eff[s] + ONE;
      if (flush_done)                   fill_q <= '0;
      else if (restart)                 fill_q <= ONE;
      else if (adv && fill_q != CNT_MAX) fill_q <= fill_q + ONE;
      if (out_valid) out_idx_q <= out_idx_q + ONE;
    end
  end

`ifdef FFT_SDF_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)          frame_cnt_q <= '0;
    else if (out_eop) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// Scoreboard bench for fft_sdf_ctrl (LOG2N = 4).
module tb_fft_sdf_ctrl;
  localparam int LOG2N = 4;
  localparam int N = 16;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_sop, flush_en;
  logic             in_ready, zero_inj, out_valid, out_sop, out_eop, busy;
  logic [LOG2N-1:0] bf_valid, bf_ctrl, out_idx;
  logic [15:0]      frame_cnt;

  fft_sdf_ctrl #(.LOG2N(LOG2N), .FLUSH_EN_DEFAULT(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_ready(in_ready),
    .flush_en(flush_en), .bf_valid(bf_valid), .bf_ctrl(bf_ctrl), .zero_inj(zero_inj),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_idx(out_idx),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int exp_q[$];
  int out_cnt = 0, sop_cnt = 0, eop_cnt = 0, z_cnt = 0, run = 0, max_run = 0;
  int mon_e;
  int b_out, b_sop, b_z;
  int last_ctrl;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (zero_inj) z_cnt++;
      if (out_valid) begin
        out_cnt++;
        run++;
        if (run > max_run) max_run = run;
        if (out_sop) sop_cnt++;
        if (out_eop) eop_cnt++;
        if (exp_q.size() == 0) chk("extra_out", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("out_idx", int'(out_idx), mon_e);
          chk("out_sop", int'(out_sop), int'(mon_e == 0));
          chk("out_eop", int'(out_eop), int'(mon_e == N - 1));
        end
      end else run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_out = out_cnt;
    b_sop = sop_cnt;
    b_z   = z_cnt;
  endtask

  task automatic send(input bit sop, input int idx, input bit keep);
    in_valid = 1'b1;
    in_sop   = sop;
    if (keep) exp_q.push_back(idx);
    @(negedge clk);
    last_ctrl = (idx >= N / 2) ? 1 : 0;
    chk("adv", int'(bf_valid[0]), 1);
    chk("ctrl0", int'(bf_ctrl[0]), last_ctrl);
    tick();
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    @(negedge clk);
    chk("gap_adv", int'(bf_valid[0]), 0);
    chk("ctrl_hold", int'(bf_ctrl[0]), last_ctrl);
    tick();
  endtask

  task automatic drain(input string tag, input int want_out, input int want_sop, input int want_z);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    chk({tag, "_drain"}, int'(busy || exp_q.size() != 0), 0);
    repeat (6) tick();
    chk({tag, "_outs"}, out_cnt - b_out, want_out);
    chk({tag, "_sops"}, sop_cnt - b_sop, want_sop);
    chk({tag, "_zeros"}, z_cnt - b_z, want_z);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; flush_en = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_oval", int'(out_valid), 0);
    chk("rst_bfv", int'(bf_valid), 0);
    chk("rst_zinj", int'(zero_inj), 0);
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_fcnt", int'(frame_cnt), 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // single frame with auto-flush
    mark();
    for (int i = 0; i < N; i++) send(i == 0, i, 1'b1);
    drain("single", 16, 1, 15);

    // two back-to-back frames
    mark();
    for (int i = 0; i < 2 * N; i++) send((i % N) == 0, i % N, 1'b1);
    drain("b2b", 32, 2, 15);
    chk("b2b_run", max_run, 32);

    // gapped frame
    mark();
    for (int i = 0; i < N; i++) begin
      send(i == 0, i, 1'b1);
      if (i < N - 1) gap();
    end
    drain("gap", 16, 1, 15);

    // data without sop while idle is dropped
    in_valid = 1'b1; in_sop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_bfv", int'(bf_valid), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_ready", int'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // aborted frame: sop again at sample 5
    mark();
    for (int i = 0; i < 5; i++) send(i == 0, i, 1'b0);
    for (int i = 0; i < N; i++) send(i == 0, i, 1'b1);
    drain("abort", 16, 1, 15);

`ifdef FFT_SDF_CTRL_FRAME_CNT_EN
    chk("frame_cnt", int'(frame_cnt), eop_cnt);
`else
    chk("frame_cnt", int'(frame_cnt), 0);
`endif

    // reset while flushing
    for (int i = 0; i < N; i++) send(i == 0, i, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("flush_zinj", int'(zero_inj), 1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rstf_busy", int'(busy), 0);
    chk("rstf_oval", int'(out_valid), 0);
    chk("rstf_ready", int'(in_ready), 1);
    chk("rstf_fcnt", int'(frame_cnt), 0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
